// File: rtl/exec_ctrl_pkg.sv
// rtl/exec_ctrl_pkg.sv - shared state codes, parameter defaults and sizing helper for exec_ctrl
package exec_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BREAK = 2'd3
   } exec_state_t;

   localparam int unsigned RUN_DIV_DEFAULT  = 32'd50_000_000;
   localparam int unsigned DEBOUNCE_DEFAULT = 32'd1_000_000;

   // Bits needed to hold 0..max_count-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_count);
      return (max_count > 32'd1) ? $clog2(max_count) : 32'd1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, level debouncer and rising-edge pulse
module btn_debounce
   import exec_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_rise
);

   localparam int unsigned CW = cnt_width(DEBOUNCE);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 32'd1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_rise;
   logic [CW-1:0] r_cnt;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive samples that disagree with the accepted level; any agreeing
   // sample restarts the count. The DEBOUNCE-th disagreeing sample flips the level.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
      end else if (r_sync2 == r_level) begin
         r_cnt  <= '0;
         r_rise <= 1'b0;
      end else if (r_cnt == LAST) begin
         r_cnt   <= '0;
         r_level <= r_sync2;
         r_rise  <= r_sync2;
      end else begin
         r_cnt  <= r_cnt + CW'(1);
         r_rise <= 1'b0;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - run/step/breakpoint execution controller for a single-cycle datapath
module exec_ctrl
   import exec_ctrl_pkg::*;
#(
   parameter int unsigned RUN_DIV  = RUN_DIV_DEFAULT,
   parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
)(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        RunSw,
   input  logic        StepBtn,
   input  logic        BpEnable,
   input  logic [31:0] BpAddr,
   input  logic [31:0] PCResult,
   input  logic [31:0] v0,
   input  logic [31:0] v1,
   output logic        CpuEn,
   output logic [15:0] DispLeft,
   output logic [15:0] DispRight,
   output logic [31:0] InstrCount,
   output logic [1:0]  State
);

   localparam int unsigned CW = cnt_width(RUN_DIV);
   localparam logic [CW-1:0] WRAP = CW'(RUN_DIV - 32'd1);

   exec_state_t   r_state;
   exec_state_t   w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_cpu_en;
   logic          w_pulse_nxt;
   logic          r_run_s1;
   logic          r_run_s2;
   logic          w_step_req;
   logic          w_wrap;
   logic          w_bp_hit;
   logic [31:0]   r_instr;
   logic [15:0]   r_disp_l;
   logic [15:0]   r_disp_r;

   // Only the low halves of the result registers are displayed.
   logic          w_unused;
   assign w_unused = &{1'b0, v0[31:16], v1[31:16]};

   btn_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_step_db (
      .i_clk   (Clk),
      .i_rst_n (Reset),
      .i_btn   (StepBtn),
      .o_rise  (w_step_req)
   );

   // Run switch only needs synchronizing; it is a level, not an event.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_run_s1 <= 1'b0;
         r_run_s2 <= 1'b0;
      end else begin
         r_run_s1 <= RunSw;
         r_run_s2 <= r_run_s1;
      end
   end

   assign w_wrap   = (r_cnt == WRAP);
   assign w_bp_hit = BpEnable && (PCResult == BpAddr);

   // Next state, prescaler and pulse; the prescaler sits at zero outside RUN so
   // every entry into RUN starts a fresh RUN_DIV period.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_pulse_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_run_s2) begin
               w_state_nxt = ST_RUN;
            end else if (w_step_req) begin
               w_state_nxt = ST_STEP;
               w_pulse_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            if (!r_run_s2) begin
               w_state_nxt = ST_IDLE;
            end else if (w_wrap) begin
               if (w_bp_hit) begin
                  w_state_nxt = ST_BREAK;
               end else begin
                  w_pulse_nxt = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_STEP: begin
            w_state_nxt = ST_IDLE;
         end
         ST_BREAK: begin
            if (w_step_req) begin
               w_state_nxt = ST_STEP;
               w_pulse_nxt = 1'b1;
            end else if (!r_run_s2) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register; CpuEn is registered alongside so it lines up with the STEP state.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_cpu_en <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_cpu_en <= w_pulse_nxt;
      end
   end

   // Saturating pulse counter and display snapshot of the datapath results.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_instr  <= '0;
         r_disp_l <= '0;
         r_disp_r <= '0;
      end else begin
         if (w_pulse_nxt && (r_instr != 32'hFFFF_FFFF)) begin
            r_instr <= r_instr + 32'd1;
         end
         if (r_cpu_en || (r_state == ST_IDLE) || (r_state == ST_BREAK)) begin
            r_disp_l <= v1[15:0];
            r_disp_r <= v0[15:0];
         end
      end
   end

   assign CpuEn      = r_cpu_en;
   assign InstrCount = r_instr;
   assign DispLeft   = r_disp_l;
   assign DispRight  = r_disp_r;
   assign State      = r_state;

endmodule

// File: tb/tb_exec_ctrl.sv
// tb/tb_exec_ctrl.sv - self-checking bench for exec_ctrl with DEBOUNCE=4, RUN_DIV=3
module tb_exec_ctrl;

   localparam int unsigned RUN_DIV  = 3;
   localparam int unsigned DEBOUNCE = 4;
   // Inputs change just after edge 0; two synchronizer flops put them in front of
   // the FSM after edge 2, so the FSM reacts at edge 3. A step press also spends
   // DEBOUNCE edges being accepted and one edge turning into the STEP pulse.
   localparam int SYNC       = 2;
   localparam int RUN_ENTRY  = SYNC + 1;
   localparam int STEP_EDGE  = SYNC + int'(DEBOUNCE) + 1;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        RunSw = 1'b0;
   logic        StepBtn = 1'b0;
   logic        BpEnable = 1'b0;
   logic [31:0] BpAddr = 32'hFFFF_FFFF;
   logic [31:0] PCResult = 32'h0;
   logic [31:0] v0 = 32'h0;
   logic [31:0] v1 = 32'h0;
   logic        CpuEn;
   logic [15:0] DispLeft;
   logic [15:0] DispRight;
   logic [31:0] InstrCount;
   logic [1:0]  State;

   int total = 0;
   int bad = 0;
   int exp_count = 0;

   exec_ctrl #(
      .RUN_DIV  (RUN_DIV),
      .DEBOUNCE (DEBOUNCE)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .RunSw      (RunSw),
      .StepBtn    (StepBtn),
      .BpEnable   (BpEnable),
      .BpAddr     (BpAddr),
      .PCResult   (PCResult),
      .v0         (v0),
      .v1         (v1),
      .CpuEn      (CpuEn),
      .DispLeft   (DispLeft),
      .DispRight  (DispRight),
      .InstrCount (InstrCount),
      .State      (State)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cpuen"}, 32'(CpuEn), 32'd0);
      chk({tag, "_count"}, InstrCount, 32'd0);
      chk({tag, "_dispL"}, 32'(DispLeft), 32'd0);
      chk({tag, "_dispR"}, 32'(DispRight), 32'd0);
      chk({tag, "_state"}, 32'(State), 32'd0);
   endtask

   // Hold StepBtn high for len cycles from IDLE; a press fires iff len >= DEBOUNCE.
   task automatic do_press(input int len, input string tag);
      bit fire;
      bit p;
      fire = (len >= int'(DEBOUNCE));
      StepBtn = 1'b1;
      for (int i = 1; i <= len + 10; i++) begin
         tick();
         p = fire && (i == STEP_EDGE);
         if (p) exp_count++;
         chk($sformatf("%s_cpuen_%0d", tag, i), 32'(CpuEn), 32'(p));
         chk($sformatf("%s_state_%0d", tag, i), 32'(State), p ? 32'd2 : 32'd0);
         chk($sformatf("%s_count_%0d", tag, i), InstrCount, 32'(exp_count));
         if (i == len) StepBtn = 1'b0;
      end
   endtask

   // Pulses land RUN_DIV, 2*RUN_DIV, ... edges after RUN entry and stop once the
   // low switch reaches the FSM, which is n edges after entry.
   function automatic bit run_pulse(input int i, input int n);
      return (i > RUN_ENTRY) && (((i - RUN_ENTRY) % int'(RUN_DIV)) == 0) && (i < n + RUN_ENTRY);
   endfunction

   task automatic do_run(input int n, input string tag);
      bit p;
      logic [31:0] last_v0;
      logic [31:0] last_v1;
      RunSw = 1'b1;
      v0 = $urandom;
      v1 = $urandom;
      for (int i = 1; i <= n + 6; i++) begin
         last_v0 = v0;
         last_v1 = v1;
         tick();
         p = run_pulse(i, n);
         if (p) exp_count++;
         chk($sformatf("%s_cpuen_%0d", tag, i), 32'(CpuEn), 32'(p));
         chk($sformatf("%s_state_%0d", tag, i), 32'(State),
             ((i >= RUN_ENTRY) && (i < n + RUN_ENTRY)) ? 32'd1 : 32'd0);
         chk($sformatf("%s_count_%0d", tag, i), InstrCount, 32'(exp_count));
         if (run_pulse(i - 1, n)) begin
            chk($sformatf("%s_dispR_%0d", tag, i), 32'(DispRight), 32'(last_v0[15:0]));
            chk($sformatf("%s_dispL_%0d", tag, i), 32'(DispLeft), 32'(last_v1[15:0]));
         end
         if (i == n) RunSw = 1'b0;
         v0 = $urandom;
         v1 = $urandom;
      end
   endtask

   initial begin
      logic [31:0] rv0;
      logic [31:0] rv1;
      int exp_st;
      int waited;

      // Reset state
      tick();
      tick();
      chk_all_zero("reset");
      Reset = 1'b1;
      tick();
      tick();
      chk_all_zero("post_reset");

      // Display follows v0/v1 every cycle while idle
      for (int k = 0; k < 6; k++) begin
         rv0 = (k == 0) ? 32'h0000_ABCD : $urandom;
         rv1 = (k == 0) ? 32'h0000_1234 : $urandom;
         v0 = rv0;
         v1 = rv1;
         tick();
         chk($sformatf("idle_dispR_%0d", k), 32'(DispRight), 32'(rv0[15:0]));
         chk($sformatf("idle_dispL_%0d", k), 32'(DispLeft), 32'(rv1[15:0]));
      end

      // Single step: long press, debounce boundary, random lengths
      do_press(10, "step10");
      chk("step10_total", InstrCount, 32'd1);
      do_press(3, "step3");
      do_press(4, "step4");
      for (int k = 0; k < 6; k++) begin
         do_press(int'($urandom_range(1, 7)), $sformatf("rstep%0d", k));
      end

      // Bouncing button never settles long enough
      for (int i = 1; i <= 14; i++) begin
         StepBtn = (i <= 4) ? ((i % 2) == 1) : 1'b0;
         tick();
         chk($sformatf("bounce_cpuen_%0d", i), 32'(CpuEn), 32'd0);
         chk($sformatf("bounce_count_%0d", i), InstrCount, 32'(exp_count));
      end

      // Free run: 12 cycles of RunSw gives (12-1)/RUN_DIV = 3 pulses
      waited = exp_count;
      do_run(12, "run12");
      chk("run12_pulses", InstrCount, 32'(waited + 3));
      for (int k = 0; k < 4; k++) begin
         do_run(int'($urandom_range(1, 20)), $sformatf("rrun%0d", k));
      end

      // Breakpoint hit at first wrap: RUN at edges 3..5, BREAK from edge 6
      BpEnable = 1'b1;
      BpAddr = 32'h0000_0010;
      PCResult = 32'h0000_0010;
      RunSw = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         tick();
         exp_st = (i < RUN_ENTRY) ? 0 : (i < RUN_ENTRY + int'(RUN_DIV)) ? 1 : 3;
         chk($sformatf("bp_cpuen_%0d", i), 32'(CpuEn), 32'd0);
         chk($sformatf("bp_state_%0d", i), 32'(State), 32'(exp_st));
      end

      // Step out of BREAK with RunSw still high: STEP, IDLE, RUN, then BREAK again
      StepBtn = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == STEP_EDGE) exp_count++;
         if (i < STEP_EDGE) exp_st = 3;
         else if (i == STEP_EDGE) exp_st = 2;
         else if (i == STEP_EDGE + 1) exp_st = 0;
         else if (i < STEP_EDGE + 2 + int'(RUN_DIV)) exp_st = 1;
         else exp_st = 3;
         chk($sformatf("bpstep_cpuen_%0d", i), 32'(CpuEn), 32'(i == STEP_EDGE));
         chk($sformatf("bpstep_state_%0d", i), 32'(State), 32'(exp_st));
         chk($sformatf("bpstep_count_%0d", i), InstrCount, 32'(exp_count));
         if (i == 6) StepBtn = 1'b0;
      end
      RunSw = 1'b0;
      BpEnable = 1'b0;
      for (int i = 1; i <= 5; i++) tick();
      chk("bp_exit_state", 32'(State), 32'd0);

      // Reset in the middle of RUN once five pulses have been issued
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      exp_count = 0;
      tick();
      chk("rst2_count", InstrCount, 32'd0);
      RunSw = 1'b1;
      waited = 0;
      while ((InstrCount != 32'd5) && (waited < 100)) begin
         tick();
         waited++;
      end
      chk("rst_reach5", InstrCount, 32'd5);
      tick();
      #2;
      Reset = 1'b0;
      RunSw = 1'b0;
      #1;
      chk_all_zero("midrun_rst");
      tick();
      tick();
      chk_all_zero("midrun_rst_held");
      Reset = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk($sformatf("after_rst_cpuen_%0d", i), 32'(CpuEn), 32'd0);
         chk($sformatf("after_rst_state_%0d", i), 32'(State), 32'd0);
         chk($sformatf("after_rst_count_%0d", i), InstrCount, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
